// File: rtl/trigger_seq_gen.sv
// trigger_seq_gen: multi-stage ADC threshold sequencer.
// The sequence is: a start pulse, then a stop pulse, then a fire pulse. The
// start-to-stop time of flight is measured, replayed as a scaled delay, and
// then followed by a trigger output.
module trigger_seq_gen #(
    parameter int NUM_CH         = 4,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int CNT_WIDTH      = 32,
    parameter int FRAC_BITS      = 16,
    parameter int CH_SEL_W       = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH*2*ADC_DATA_WIDTH-1:0] adc_data,
    input  logic [NUM_CH-1:0]               adc_valid,
    input  logic                            trig_enable,
    input  logic                            auto_rearm,
    input  logic [CNT_WIDTH-1:0]            holdoff_cycles,
    input  logic [CNT_WIDTH-1:0]            timeout_cycles,
    input  logic [3*CH_SEL_W-1:0]           stage_chan,
    input  logic [2:0]                      stage_pol,
    input  logic [3*ADC_DATA_WIDTH-1:0]     stage_level,
    input  logic [CNT_WIDTH-1:0]            delay_mul,
    output logic [CNT_WIDTH-1:0]            pulse_tof,
    output logic                            detect_pls_0,
    output logic                            detect_pls_1,
    output logic                            timeout_flag,
    output logic [2:0]                      state_o
);

    localparam int SW = ADC_DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] DLY_STEP = CNT_ONE << FRAC_BITS;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_START_HIT = 3'd2,
        ST_STOP_HIT  = 3'd3,
        ST_DELAY     = 3'd4,
        ST_TRIGGER   = 3'd5
    } state_t;

    state_t                   state_r;
    logic signed [SW-1:0]     sum_r [NUM_CH];
    logic [CNT_WIDTH-1:0]     hold_cnt_r;
    logic [CNT_WIDTH-1:0]     tof_acc_r;
    logic [CNT_WIDTH-1:0]     dly_cnt_r;
    logic [CNT_WIDTH-1:0]     tmo_cnt_r;
    logic                     en_d_r;

    logic [2:0]               stage_match_s;
    logic [CH_SEL_W-1:0]      chan_s;
    logic signed [SW-1:0]     lvl_s;
    logic signed [SW-1:0]     sel_s;
    logic                     sel_hit_s;
    logic                     tmo_expire_s;

    // Sign-extend both samples of a pair and add them at one extra bit.
    function automatic logic [SW-1:0] pair_sum(input logic [2*ADC_DATA_WIDTH-1:0] pair);
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        a = {pair[ADC_DATA_WIDTH-1], pair[ADC_DATA_WIDTH-1:0]};
        b = {pair[2*ADC_DATA_WIDTH-1], pair[2*ADC_DATA_WIDTH-1:ADC_DATA_WIDTH]};
        return a + b;
    endfunction

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                      input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (full[CNT_WIDTH]) begin
            return {CNT_WIDTH{1'b1}};
        end else begin
            return full[CNT_WIDTH-1:0];
        end
    endfunction

    // Register per-channel sample-pair sums; hold them while a channel is not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sum_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (adc_valid[k]) begin
                    sum_r[k] <= $signed(pair_sum(adc_data[k*2*ADC_DATA_WIDTH +: 2*ADC_DATA_WIDTH]));
                end
            end
        end
    end

    // Evaluate each stage's strict threshold compare; out-of-range channels never match.
    always_comb begin
        stage_match_s = 3'b000;
        chan_s        = '0;
        lvl_s         = '0;
        sel_s         = '0;
        sel_hit_s     = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chan_s    = stage_chan[s*CH_SEL_W +: CH_SEL_W];
            lvl_s     = $signed({stage_level[s*ADC_DATA_WIDTH +: ADC_DATA_WIDTH], 1'b0});
            sel_s     = '0;
            sel_hit_s = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (chan_s == CH_SEL_W'(k)) begin
                    sel_s     = sum_r[k];
                    sel_hit_s = 1'b1;
                end else begin
                    sel_s     = sel_s;
                end
            end
            if (!sel_hit_s) begin
                stage_match_s[s] = 1'b0;
            end else if (stage_pol[s]) begin
                stage_match_s[s] = (sel_s > lvl_s);
            end else begin
                stage_match_s[s] = (sel_s < lvl_s);
            end
        end
    end

    // Timeout fires on the cycle the dwell counter would reach the programmed limit.
    always_comb begin
        if (timeout_cycles != '0) begin
            tmo_expire_s = (tmo_cnt_r >= (timeout_cycles - CNT_ONE));
        end else begin
            tmo_expire_s = 1'b0;
        end
    end

    // Sequence FSM together with its counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            detect_pls_0 <= 1'b0;
            detect_pls_1 <= 1'b0;
            timeout_flag <= 1'b0;
            pulse_tof    <= '0;
            hold_cnt_r   <= holdoff_cycles;
            tof_acc_r    <= '0;
            dly_cnt_r    <= '0;
            tmo_cnt_r    <= '0;
            en_d_r       <= 1'b0;
        end else begin
            en_d_r <= trig_enable;
            // Re-enabling is the only way besides reset to clear a past timeout.
            if (trig_enable && !en_d_r) begin
                timeout_flag <= 1'b0;
            end
            if (!trig_enable) begin
                state_r      <= ST_IDLE;
                detect_pls_0 <= 1'b0;
                detect_pls_1 <= 1'b0;
                hold_cnt_r   <= holdoff_cycles;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        detect_pls_0 <= 1'b0;
                        detect_pls_1 <= 1'b0;
                        if (hold_cnt_r == '0) begin
                            state_r <= ST_ARMED;
                        end else begin
                            hold_cnt_r <= hold_cnt_r - CNT_ONE;
                        end
                    end
                    ST_ARMED: begin
                        if (stage_match_s[0]) begin
                            state_r      <= ST_START_HIT;
                            detect_pls_0 <= 1'b1;
                            tof_acc_r    <= '0;
                            tmo_cnt_r    <= '0;
                        end
                    end
                    ST_START_HIT: begin
                        // A stop match wins over a timeout on the same cycle.
                        if (stage_match_s[1]) begin
                            pulse_tof <= tof_acc_r;
                            state_r   <= ST_STOP_HIT;
                            tmo_cnt_r <= '0;
                        end else if (tmo_expire_s) begin
                            state_r      <= ST_IDLE;
                            detect_pls_0 <= 1'b0;
                            detect_pls_1 <= 1'b0;
                            timeout_flag <= 1'b1;
                            hold_cnt_r   <= holdoff_cycles;
                        end else begin
                            tof_acc_r <= sat_add(tof_acc_r, delay_mul);
                            if (timeout_cycles != '0) begin
                                tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_STOP_HIT: begin
                        if (stage_match_s[2]) begin
                            state_r      <= ST_DELAY;
                            dly_cnt_r    <= '0;
                            detect_pls_0 <= 1'b0;
                        end else if (tmo_expire_s) begin
                            state_r      <= ST_IDLE;
                            detect_pls_0 <= 1'b0;
                            detect_pls_1 <= 1'b0;
                            timeout_flag <= 1'b1;
                            hold_cnt_r   <= holdoff_cycles;
                        end else begin
                            if (timeout_cycles != '0) begin
                                tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_DELAY: begin
                        // The delay counter runs in fixed point, so one step equals one tof unit.
                        if (dly_cnt_r >= pulse_tof) begin
                            state_r      <= ST_TRIGGER;
                            detect_pls_0 <= 1'b1;
                            detect_pls_1 <= 1'b1;
                        end else begin
                            dly_cnt_r <= sat_add(dly_cnt_r, DLY_STEP);
                        end
                    end
                    ST_TRIGGER: begin
                        if (auto_rearm) begin
                            state_r      <= ST_IDLE;
                            detect_pls_0 <= 1'b0;
                            detect_pls_1 <= 1'b0;
                            hold_cnt_r   <= holdoff_cycles;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        detect_pls_0 <= 1'b0;
                        detect_pls_1 <= 1'b0;
                        hold_cnt_r   <= holdoff_cycles;
                    end
                endcase
            end
        end
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_trigger_seq_gen.sv
// Self-checking bench for trigger_seq_gen: directed scenarios, a cycle-level
// reference model compared every cycle, and literal expectations.
module tb_trigger_seq_gen;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int CW  = 32;
    localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;
    localparam int S_IDLE = 0, S_ARMED = 1, S_START = 2, S_STOP = 3, S_DELAY = 4, S_TRIG = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*2*W-1:0] adc_data;
    logic [NCH-1:0]    adc_valid;
    logic              trig_enable, auto_rearm;
    logic [CW-1:0]     holdoff_cycles, timeout_cycles, delay_mul;
    logic [8:0]        stage_chan;
    logic [2:0]        stage_pol;
    logic [3*W-1:0]    stage_level;
    logic [CW-1:0]     pulse_tof;
    logic              detect_pls_0, detect_pls_1, timeout_flag;
    logic [2:0]        state_o;

    int n_tests = 0;
    int n_fail  = 0;

    trigger_seq_gen dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .trig_enable(trig_enable), .auto_rearm(auto_rearm),
        .holdoff_cycles(holdoff_cycles), .timeout_cycles(timeout_cycles),
        .stage_chan(stage_chan), .stage_pol(stage_pol), .stage_level(stage_level),
        .delay_mul(delay_mul), .pulse_tof(pulse_tof), .detect_pls_0(detect_pls_0),
        .detect_pls_1(detect_pls_1), .timeout_flag(timeout_flag), .state_o(state_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_sum [NCH];
    int              m_state;
    bit              m_d0, m_d1, m_tf, m_en_prev, m_valid = 1'b0;
    longint unsigned m_hold, m_tof, m_dly, m_tmo, m_ptof;

    function automatic bit stage_hits(input int s);
        int chan, lvl;
        chan = int'(stage_chan[s*3 +: 3]);
        lvl  = int'($signed(stage_level[s*W +: W]));
        if (chan >= NCH) return 1'b0;
        return stage_pol[s] ? (m_sum[chan] > 2*lvl) : (m_sum[chan] < 2*lvl);
    endfunction

    function automatic longint unsigned capped(input longint unsigned x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic go_idle();
        m_state = S_IDLE; m_d0 = 0; m_d1 = 0; m_hold = holdoff_cycles;
    endtask

    task automatic dwell_tick();
        if (timeout_cycles != 0) begin
            m_tmo++;
            if (m_tmo >= timeout_cycles) begin
                go_idle();
                m_tf = 1;
            end
        end
    endtask

    task automatic model_step();
        bit [2:0] hit;
        logic signed [W-1:0] a, b;
        for (int s = 0; s < 3; s++) hit[s] = stage_hits(s);
        if (rst) begin
            m_state = S_IDLE; m_d0 = 0; m_d1 = 0; m_tf = 0; m_ptof = 0;
            m_hold = holdoff_cycles; m_tof = 0; m_dly = 0; m_tmo = 0;
            m_en_prev = 0; m_valid = 1;
            for (int k = 0; k < NCH; k++) m_sum[k] = 0;
            return;
        end
        for (int k = 0; k < NCH; k++) begin
            if (adc_valid[k]) begin
                a = adc_data[k*2*W +: W];
                b = adc_data[k*2*W+W +: W];
                m_sum[k] = int'(a) + int'(b);
            end
        end
        if (trig_enable && !m_en_prev) m_tf = 0;
        m_en_prev = trig_enable;
        if (!trig_enable) begin
            go_idle();
        end else begin
            case (m_state)
                S_IDLE:  if (m_hold == 0) m_state = S_ARMED; else m_hold--;
                S_ARMED: if (hit[0]) begin m_state = S_START; m_d0 = 1; m_tof = 0; m_tmo = 0; end
                S_START: if (hit[1]) begin m_ptof = m_tof; m_state = S_STOP; m_tmo = 0; end
                         else begin m_tof = capped(m_tof + delay_mul); dwell_tick(); end
                S_STOP:  if (hit[2]) begin m_state = S_DELAY; m_dly = 0; m_d0 = 0; end
                         else dwell_tick();
                S_DELAY: if (m_dly >= m_ptof) begin m_state = S_TRIG; m_d0 = 1; m_d1 = 1; end
                         else m_dly = capped(m_dly + 64'd65536);
                S_TRIG:  if (auto_rearm) go_idle();
                default: go_idle();
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("state_o", state_o, m_state);
            chk("detect_pls_0", detect_pls_0, m_d0);
            chk("detect_pls_1", detect_pls_1, m_d1);
            chk("timeout_flag", timeout_flag, m_tf);
            chk("pulse_tof", pulse_tof, m_ptof);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pair(input int ch, input int a, input int b);
        adc_data[ch*2*W +: W]   = W'(a);
        adc_data[ch*2*W+W +: W] = W'(b);
    endtask

    task automatic pulse(input int ch, input int a, input int b);
        set_pair(ch, a, b);
        tick(1);
        set_pair(ch, 0, 0);
    endtask

    task automatic wait_state(input int s, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (state_o != 3'(s) && cnt < limit);
        if (state_o != 3'(s)) chk("wait_state", state_o, s);
    endtask

    task automatic wait_det1(input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (detect_pls_1 !== 1'b1 && cnt < limit);
        if (detect_pls_1 !== 1'b1) chk("wait_det1", detect_pls_1, 1);
    endtask

    // From ARMED: start pulse, 20 accumulation steps, stop pulse, fire pulse; returns in DELAY.
    task automatic run_seq();
        int c;
        pulse(0, 1200, 900);
        wait_state(S_START, 5, c);
        tick(19);
        pulse(1, -600, -500);
        wait_state(S_STOP, 5, c);
        pulse(2, 1100, 1000);
        wait_state(S_DELAY, 5, c);
    endtask

    initial begin
        int cnt;
        rst = 1; trig_enable = 1; auto_rearm = 1;
        holdoff_cycles = 32'd10; timeout_cycles = 32'd0; delay_mul = 32'd3;
        stage_chan = {3'd2, 3'd1, 3'd0};
        stage_pol = 3'b101;
        stage_level = {16'd1000, -16'sd500, 16'd1000};
        adc_data = '0; adc_valid = 4'b1111;
        @(negedge clk);
        chk("reset_state", state_o, 0);
        chk("reset_det0", detect_pls_0, 0);
        chk("reset_det1", detect_pls_1, 0);
        chk("reset_tflag", timeout_flag, 0);
        chk("reset_tof", pulse_tof, 0);
        rst = 0;

        // Basic sequence
        wait_state(S_ARMED, 40, cnt);
        chk("arm_latency", cnt, 11);
        run_seq();
        chk("basic_tof", pulse_tof, 60);
        wait_det1(10, cnt);
        chk("fire_latency", cnt, 2);
        chk("trig_det0", detect_pls_0, 1);
        chk("trig_state", state_o, S_TRIG);
        tick(1);
        chk("rearm_idle", state_o, S_IDLE);
        chk("rearm_det1", detect_pls_1, 0);
        wait_state(S_ARMED, 40, cnt);
        chk("rearm_latency", cnt, 11);

        // Boundary compare
        set_pair(0, 1000, 1000);
        tick(3);
        chk("eq_rising", state_o, S_ARMED);
        stage_pol[0] = 1'b0;
        tick(3);
        chk("eq_falling", state_o, S_ARMED);
        stage_pol[0] = 1'b1;
        set_pair(0, 1001, 1000);
        wait_state(S_START, 5, cnt);
        chk("plus1_rising", cnt, 2);
        set_pair(0, 0, 0);

        // Abort from START_HIT keeps pulse_tof
        trig_enable = 0;
        tick(1);
        chk("abort_state", state_o, S_IDLE);
        chk("abort_det0", detect_pls_0, 0);
        chk("abort_tof", pulse_tof, 60);

        // Timeout with no stop pulse
        timeout_cycles = 32'd50;
        trig_enable = 1;
        wait_state(S_ARMED, 40, cnt);
        pulse(0, 1200, 900);
        wait_state(S_START, 5, cnt);
        cnt = 1;
        while (cnt < 100) begin
            @(negedge clk);
            if (state_o != 3'(S_START)) break;
            cnt++;
        end
        chk("timeout_dwell", cnt, 50);
        chk("timeout_state", state_o, S_IDLE);
        chk("timeout_flag", timeout_flag, 1);
        chk("timeout_det0", detect_pls_0, 0);

        // Flag clears only on enable rising edge
        trig_enable = 0;
        tick(2);
        chk("flag_sticky", timeout_flag, 1);
        trig_enable = 1;
        tick(1);
        chk("flag_cleared", timeout_flag, 0);

        // Hold TRIGGER with auto_rearm=0
        auto_rearm = 0;
        wait_state(S_ARMED, 40, cnt);
        run_seq();
        wait_det1(10, cnt);
        tick(5);
        chk("hold_state", state_o, S_TRIG);
        chk("hold_det1", detect_pls_1, 1);
        trig_enable = 0;
        tick(1);
        chk("hold_exit_state", state_o, S_IDLE);
        chk("hold_exit_det1", detect_pls_1, 0);
        trig_enable = 1;
        auto_rearm = 1;

        // Reset asserted in DELAY
        wait_state(S_ARMED, 40, cnt);
        run_seq();
        rst = 1;
        tick(1);
        chk("rst_state", state_o, S_IDLE);
        chk("rst_det0", detect_pls_0, 0);
        chk("rst_det1", detect_pls_1, 0);
        chk("rst_tof", pulse_tof, 0);
        rst = 0;

        // Saturation
        delay_mul = 32'hFFFF_FFFF;
        timeout_cycles = 32'd0;
        wait_state(S_ARMED, 40, cnt);
        run_seq();
        chk("sat_tof", pulse_tof, 64'h0000_0000_FFFF_FFFF);
        wait_det1(70000, cnt);
        chk("sat_fire_state", state_o, S_TRIG);

        // Out-of-range channel select never matches
        wait_state(S_ARMED, 40, cnt);
        stage_chan = {3'd2, 3'd1, 3'd4};
        for (int k = 0; k < NCH; k++) set_pair(k, 1100, 1000);
        tick(5);
        chk("chan_oor", state_o, S_ARMED);
        stage_chan = {3'd2, 3'd1, 3'd0};
        wait_state(S_START, 5, cnt);
        chk("chan_restore", cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_seq_gen.md
TRIGGER_SEQ_GEN -- requirements
Module: trigger_seq_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_CH, 4, ADC channels, 2..8.
- ADC_DATA_WIDTH, 16, sample width; two samples per channel word.
- CNT_WIDTH, 32, width of the time-of-flight, delay and timeout counters.
- FRAC_BITS, 16, fixed-point fraction bits of the delay counter step.
- CH_SEL_W, 3, channel-select width; SHALL be at least clog2(NUM_CH).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: 125 MHz ADC clock, two samples per cycle.
- rst, in, 1: synchronous active-high reset.
- adc_data, in, NUM_CH*2*ADC_DATA_WIDTH: channel k occupies slice k; lower half is sample 0.
- adc_valid, in, NUM_CH: per-channel sample-pair valid.
- trig_enable, in, 1: arm; low forces IDLE.
- auto_rearm, in, 1: 1 = after TRIGGER return to IDLE; 0 = hold TRIGGER.
- holdoff_cycles, in, CNT_WIDTH: IDLE dwell before arming.
- timeout_cycles, in, CNT_WIDTH: maximum dwell in START_HIT or STOP_HIT; 0 disables timeout.
- stage_chan, in, 3*CH_SEL_W: channel select for stages 0 (start), 1 (stop), 2 (fire).
- stage_pol, in, 3: per stage, 1 = rising (sum > 2*level), 0 = falling (sum < 2*level).
- stage_level, in, 3*ADC_DATA_WIDTH: signed threshold per stage.
- delay_mul, in, CNT_WIDTH: time-of-flight accumulation step per cycle.
- pulse_tof, out, CNT_WIDTH: last captured time-of-flight accumulator.
- detect_pls_0, out, 1: start pulse seen.
- detect_pls_1, out, 1: delayed trigger fired.
- timeout_flag, out, 1: sticky; a sequence timed out.
- state_o, out, 3: current FSM state encoding.

Function
REQ-003 For each channel k with adc_valid[k]=1, the block SHALL register sum_k = sext(s0) + sext(s1) at ADC_DATA_WIDTH+1 bits, signed, with no overflow; sum_k SHALL hold when adc_valid[k]=0.
REQ-004 The stage compare SHALL use the registered sum_k against {level,1'b0} as a signed (ADC_DATA_WIDTH+1)-bit value, with the strict inequality given by stage_pol; a stage_chan value of NUM_CH or above SHALL never match.
REQ-005 The FSM states SHALL be IDLE=0, ARMED=1, START_HIT=2, STOP_HIT=3, DELAY=4, TRIGGER=5; unused encodings SHALL go to IDLE next cycle.
REQ-006 IDLE:
- outputs detect_pls_0=0 and detect_pls_1=0;
- hold_cnt decrements each cycle; go to ARMED the cycle after hold_cnt==0.
- hold_cnt SHALL be loaded with holdoff_cycles on every entry to IDLE.
REQ-007 ARMED: on a stage-0 match, go to START_HIT; set detect_pls_0=1, tof_acc=0 and tmo_cnt=0.
REQ-008 START_HIT:
- on a stage-1 match, pulse_tof <= tof_acc and go to STOP_HIT with tmo_cnt=0;
- otherwise tof_acc <= tof_acc + delay_mul, saturating at all-ones.
REQ-009 STOP_HIT: on a stage-2 match, go to DELAY with dly_cnt=0 and detect_pls_0=0.
REQ-010 DELAY:
- if dly_cnt >= pulse_tof, go to TRIGGER;
- else dly_cnt <= dly_cnt + 2^FRAC_BITS, saturating.
REQ-011 TRIGGER: detect_pls_0=1 and detect_pls_1=1; the output registers SHALL update on the cycle of entry, so both are visible one cycle after the DELAY exit condition.
REQ-012 TRIGGER exit: with auto_rearm=1, go to IDLE after exactly 1 cycle in TRIGGER; with auto_rearm=0, stay until trig_enable=0 or rst.
REQ-013 Timeout: in START_HIT or STOP_HIT with timeout_cycles≠0, tmo_cnt increments each cycle.
- When tmo_cnt reaches timeout_cycles, go to IDLE, clear detect_pls_0 and set timeout_flag.
- A stage match on the same cycle as the timeout SHALL take priority over the timeout.
REQ-014 timeout_flag SHALL clear only on rst or on a rising edge of trig_enable.
REQ-015 trig_enable=0 SHALL force IDLE next cycle from any state, clear detect_pls_0 and detect_pls_1, and reload hold_cnt; pulse_tof SHALL be retained.
REQ-016 Configuration inputs SHALL be sampled live; a change mid-sequence SHALL affect only subsequent compares.

Reset
REQ-017 With rst=1, the next clk edge SHALL set:
- state=IDLE;
- detect_pls_0=0, detect_pls_1=0, timeout_flag=0;
- pulse_tof=0, all sums=0;
- hold_cnt=holdoff_cycles; tof_acc, dly_cnt and tmo_cnt = 0.
REQ-018 rst SHALL take priority over trig_enable and over every state transition, including mid-sequence.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Basic sequence: holdoff=10, delay_mul=3, stages ch0 rising level 1000, ch1 falling level -500, ch2 rising level 1000; pulses separated by 20 cycles -> ARMED after 11 cycles; pulse_tof=60 (20 cycles × step 3); detect_pls_1 rises 2 cycles after the stage-2 match (dly_cnt ≥ 60 after the first step of 65536).
- Boundary compare: sum exactly equal to 2*level -> no match for either polarity; sum = 2*level+1 with rising -> match.
- Timeout: timeout_cycles=50 and no stop pulse -> IDLE after 50 cycles in START_HIT; timeout_flag=1; detect_pls_0=0.
- Sequence control: auto_rearm=1 -> one TRIGGER cycle, then holdoff, then re-arm; auto_rearm=0 -> TRIGGER held; trig_enable low then high -> IDLE and timeout_flag cleared.
- Reset and abort: rst asserted in DELAY -> all outputs 0 next cycle; trig_enable dropped in START_HIT -> IDLE with pulse_tof retained.
- Saturation and channel select: delay_mul=all-ones -> pulse_tof saturates to all-ones and the DELAY exit still occurs; stage_chan=NUM_CH -> that stage never matches.
